fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), the instruction driven on bubbles.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_i  input  1  hazard stall; decode cannot accept a new instruction.
REQ-006 SHALL have port redirect_i  input  1  branch/jump taken; kills the IF/ID entry and any in-flight fetch.
REQ-007 SHALL have port redirect_pc_i  input  32  target address; bits [1:0] are ignored and treated as 0.
REQ-008 SHALL have port imem_req_o  output  1  fetch request; the memory accepts it in the same cycle.
REQ-009 SHALL have port imem_addr_o  output  32  fetch address; meaningful only while imem_req_o=1.
REQ-010 SHALL have port imem_rvalid_i  input  1  response valid, at least 1 cycle after its request.
REQ-011 SHALL have port imem_rdata_i  input  32  fetched instruction word.
REQ-012 SHALL have port if_id_valid_o  output  1  IF/ID register holds a live instruction.
REQ-013 SHALL have port if_id_instr_o  output  32  IF/ID instruction, consumed by the decode-stage control decoder.
REQ-014 SHALL have port if_id_pc_o  output  32  PC of if_id_instr_o.
REQ-015 SHALL have port if_id_pc4_o  output  32  if_id_pc_o+4, mod 2^32.

Function
REQ-016 SHALL allow at most one outstanding imem request.
REQ-017 SHALL hold pc_q, the address of the outstanding or next fetch, plus a one-entry skid buffer (instr, pc).
REQ-018 SHALL implement states ISSUE, WAIT, HOLD and DRAIN.
REQ-019 In ISSUE with redirect_i=0, it SHALL drive imem_req_o=1 and imem_addr_o=pc_q, then go to WAIT.
REQ-020 In WAIT with rvalid=1 and stall_i=0, it SHALL load IF/ID with (rdata, pc_q) and set valid=1.
REQ-021 In the same cycle it SHALL set pc_q<=pc_q+4, drive imem_req_o=1 with imem_addr_o=pc_q+4, and stay in WAIT, giving one instruction per cycle for 1-cycle memory.
REQ-022 In WAIT with rvalid=1 and stall_i=1, it SHALL capture (rdata, pc_q) into the skid buffer, set pc_q<=pc_q+4, keep imem_req_o=0, and go to HOLD.
REQ-023 In HOLD with stall_i=0, it SHALL move the skid entry into IF/ID with valid=1 and go to ISSUE.
REQ-024 While stall_i=1 and redirect_i=0, all IF/ID outputs SHALL hold their values.
REQ-025 When stall_i=0 and no instruction loads in a cycle, IF/ID SHALL become a bubble: valid=0 and instr=NOP_INSTR, with PC outputs unchanged.
REQ-026 redirect_i SHALL take priority over stall_i and rvalid.
REQ-027 On redirect_i it SHALL force imem_req_o=0, set pc_q<=redirect_pc_i with bits[1:0]=0, and drop the skid buffer.
REQ-028 On redirect_i it SHALL also set IF/ID valid=0 and instr=NOP_INSTR.
REQ-029 On redirect_i, the next state SHALL be DRAIN if in WAIT with rvalid=0, and ISSUE otherwise; DRAIN plus redirect stays in DRAIN.
REQ-030 In DRAIN, it SHALL discard the arriving response (rvalid=1), issue nothing, and go to ISSUE.
REQ-031 PC arithmetic SHALL wrap: 32'hFFFF_FFFC+4=32'h0000_0000.
REQ-032 An rvalid arriving in ISSUE or HOLD (protocol violation) SHALL be ignored.

Reset
REQ-033 While reset_i=0, outputs SHALL be: imem_req_o=0, imem_addr_o=0, if_id_valid_o=0, if_id_instr_o=NOP_INSTR, if_id_pc_o=0, if_id_pc4_o=4.
REQ-034 While reset_i=0, internal state SHALL be pc_q=RESET_PC, state=ISSUE, skid empty.
REQ-035 reset_i assertion mid-fetch SHALL abandon the outstanding request; a late rvalid after release SHALL be ignored (state ISSUE).
REQ-036 The first request SHALL be in the first clock edge after reset_i rises: imem_req_o=1, addr=RESET_PC.

Verification
REQ-037 Reset release, 1-cycle memory, no stalls -> requests at 0x0,0x4,0x8 on consecutive cycles; IF/ID pc 0x0,0x4,0x8 with valid=1 each cycle from cycle 2.
REQ-038 stall_i=1 for 3 cycles while a response for 0x8 arrives -> IF/ID holds 0x4, skid holds 0x8, no request; after stall drops, IF/ID=0x8 then request at 0xC.
REQ-039 redirect_i with redirect_pc_i=0x103 while in WAIT, response 2 cycles later -> stale response dropped, IF/ID valid=0 with NOP, next request addr=0x100.
REQ-040 redirect_i coincident with rvalid and stall_i=1 -> no skid capture, valid=0, next cycle request at the target.
REQ-041 pc_q=0xFFFF_FFFC fetched -> IF/ID pc=0xFFFF_FFFC, pc4=0x0, next request addr=0x0.
REQ-042 reset_i pulsed low during WAIT -> outputs at reset values immediately (asynchronous); after release, request at RESET_PC; a stray rvalid is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with an IF/ID pipeline register and a one-entry
//   skid buffer. It keeps at most one instruction-memory request outstanding.
//   With a 1-cycle memory and no stalls it delivers one instruction per cycle
//   by issuing the next request in the same cycle a response is accepted.
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   reset_i        : asynchronous active-low reset
//   stall_i        : decode cannot accept a new instruction this cycle
//   redirect_i     : taken branch/jump; kills IF/ID and any in-flight fetch
//   redirect_pc_i  : redirect target, bits [1:0] forced to zero
//   imem_req_o     : fetch request, accepted by memory in the same cycle
//   imem_addr_o    : fetch address (zero when no request)
//   imem_rvalid_i  : response valid, at least one cycle after the request
//   imem_rdata_i   : fetched instruction word
//   if_id_valid_o  : IF/ID holds a live instruction
//   if_id_instr_o  : IF/ID instruction (NOP_INSTR on bubbles)
//   if_id_pc_o     : PC of if_id_instr_o
//   if_id_pc4_o    : if_id_pc_o + 4, wrapping
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o
);

  // ISSUE : nothing outstanding, request pc_q
  // WAIT  : request for pc_q outstanding
  // HOLD  : skid buffer full, waiting for decode to accept it
  // DRAIN : a killed request is still outstanding; swallow its response
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] skid_instr_q, skid_pc_q;
  logic        valid_q;
  logic [31:0] instr_q, id_pc_q;

  logic        load_fetch;    // response goes straight into IF/ID
  logic        skid_capture;  // response parked in the skid buffer
  logic        load_skid;     // skid entry moves into IF/ID

  assign pc_plus4 = pc_q + 32'd4;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_ISSUE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      // A request still in flight must be drained before issuing again. A
      // response arriving together with the redirect retires that request.
      if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !imem_rvalid_i)
        state_d = ST_DRAIN;
      else
        state_d = ST_ISSUE;
    end else begin
      case (state_q)
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT:  if (imem_rvalid_i && stall_i) state_d = ST_HOLD;
        ST_HOLD:  if (!stall_i)                 state_d = ST_ISSUE;
        ST_DRAIN: if (imem_rvalid_i)            state_d = ST_ISSUE;
        default:  state_d = ST_ISSUE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req_o   = 1'b0;
    imem_addr_o  = 32'h0;
    load_fetch   = 1'b0;
    skid_capture = 1'b0;
    load_skid    = 1'b0;
    // Gating with reset_i keeps the request low while reset is held, even
    // though the state register already reads ISSUE.
    if (reset_i && !redirect_i) begin
      case (state_q)
        ST_ISSUE: begin
          imem_req_o  = 1'b1;
          imem_addr_o = pc_q;
        end
        ST_WAIT: begin
          if (imem_rvalid_i && !stall_i) begin
            load_fetch  = 1'b1;
            // Back-to-back issue of the next sequential address.
            imem_req_o  = 1'b1;
            imem_addr_o = pc_plus4;
          end else if (imem_rvalid_i) begin
            skid_capture = 1'b1;
          end
        end
        ST_HOLD:  load_skid = !stall_i;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: fetch PC, skid buffer, IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      id_pc_q      <= 32'h0;
    end else begin
      if (redirect_i)
        pc_q <= redirect_pc_i & ~32'h3;
      else if (load_fetch || skid_capture)
        pc_q <= pc_plus4;

      if (skid_capture) begin
        skid_instr_q <= imem_rdata_i;
        skid_pc_q    <= pc_q;
      end

      if (redirect_i) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end else if (load_fetch) begin
        valid_q <= 1'b1;
        instr_q <= imem_rdata_i;
        id_pc_q <= pc_q;
      end else if (load_skid) begin
        valid_q <= 1'b1;
        instr_q <= skid_instr_q;
        id_pc_q <= skid_pc_q;
      end else if (!stall_i) begin
        // Decode consumed the entry and nothing replaces it: bubble, PC kept.
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
    end
  end

  assign if_id_valid_o = valid_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_pc4_o   = id_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Drives fetch_stage with directed scenarios and then random stall/redirect
//   traffic against a variable-latency memory. A transaction-level model of
//   the fetch stage predicts the outputs each cycle; every live IF/ID entry is
//   also checked against the memory contents at its PC.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  logic        clk_i;
  logic        reset_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed, address-dependent word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction memory responder (one request at a time, latency mem_lat or
  // random 1..3 when mem_lat is 0). stray injects one unsolicited response.
  // ---------------------------------------------------------------------------
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic        stray = 1'b0;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        mem_busy = 1'b0;
      end else begin
        if (imem_rvalid_i) mem_busy = 1'b0;
        if (imem_req_o) begin
          mem_busy = 1'b1;
          mem_addr = imem_addr_o;
          mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
        end
      end
      @(posedge clk_i);
      #1;
      if (mem_busy) mem_cnt--;
      if (stray) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = JUNK;
        stray         = 1'b0;
      end else if (mem_busy && mem_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mem_addr);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: fetch pointer, whether a request is in flight, whether
  // that request was killed, and the parked instruction if decode stalled.
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc, m_skid_instr, m_skid_pc, m_instr, m_id_pc;
  logic        m_pending, m_stale, m_skid_full, m_valid;
  logic        exp_req;
  logic [31:0] exp_addr;

  task automatic model_reset();
    m_pc = RESET_PC; m_pending = 1'b0; m_stale = 1'b0; m_skid_full = 1'b0;
    m_skid_instr = NOP; m_skid_pc = 32'h0;
    m_valid = 1'b0; m_instr = NOP; m_id_pc = 32'h0;
  endtask

  task automatic model_bubble_if_free();
    if (!stall_i) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end
  endtask

  task automatic model_advance();
    if (redirect_i) begin
      m_valid     = 1'b0;
      m_instr     = NOP;
      m_skid_full = 1'b0;
      m_stale     = m_pending && !imem_rvalid_i;
      m_pending   = m_stale;
      m_pc        = redirect_pc_i & ~32'h3;
    end else if (m_skid_full) begin
      if (!stall_i) begin
        m_valid = 1'b1; m_instr = m_skid_instr; m_id_pc = m_skid_pc;
        m_skid_full = 1'b0;
      end
    end else if (!m_pending) begin
      m_pending = 1'b1;
      m_stale   = 1'b0;
      model_bubble_if_free();
    end else if (!imem_rvalid_i) begin
      model_bubble_if_free();
    end else if (m_stale) begin
      m_pending = 1'b0;
      m_stale   = 1'b0;
      model_bubble_if_free();
    end else if (!stall_i) begin
      m_valid = 1'b1; m_instr = imem_rdata_i; m_id_pc = m_pc;
      m_pc    = m_pc + 32'd4;
    end else begin
      m_skid_instr = imem_rdata_i; m_skid_pc = m_pc; m_skid_full = 1'b1;
      m_pc      = m_pc + 32'd4;
      m_pending = 1'b0;
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        check("rst_req",   32'(imem_req_o),    32'h0);
        check("rst_addr",  imem_addr_o,        32'h0);
        check("rst_valid", 32'(if_id_valid_o), 32'h0);
        check("rst_instr", if_id_instr_o,      NOP);
        check("rst_pc",    if_id_pc_o,         32'h0);
        check("rst_pc4",   if_id_pc4_o,        32'h4);
        model_reset();
      end else begin
        exp_req  = 1'b0;
        exp_addr = 32'h0;
        if (!redirect_i && !m_skid_full) begin
          if (!m_pending) begin
            exp_req = 1'b1; exp_addr = m_pc;
          end else if (!m_stale && imem_rvalid_i && !stall_i) begin
            exp_req = 1'b1; exp_addr = m_pc + 32'd4;
          end
        end
        check("req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check("addr", imem_addr_o, exp_addr);
        check("valid", 32'(if_id_valid_o), 32'(m_valid));
        check("instr", if_id_instr_o, m_instr);
        check("pc",    if_id_pc_o,    m_id_pc);
        check("pc4",   if_id_pc4_o,   m_id_pc + 32'd4);
        if (if_id_valid_o) check("instr_vs_mem", if_id_instr_o, mem_word(if_id_pc_o));
        model_advance();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    @(posedge clk_i);
    #1;
    stall_i = s; redirect_i = r; redirect_pc_i = rpc;
    @(negedge clk_i);
  endtask

  initial begin
    logic        s, r;
    logic [31:0] rpc;
    reset_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    repeat (3) @(negedge clk_i);
    check("lit_rst_pc4", if_id_pc4_o, 32'h4);

    // Reset release, 1-cycle memory, no stalls.
    @(posedge clk_i); #1; reset_i = 1'b1; @(negedge clk_i);
    check("lit_first_req",  32'(imem_req_o), 32'h1);
    check("lit_first_addr", imem_addr_o,     32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("lit_c1_addr",  imem_addr_o, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    check("lit_c2_valid", 32'(if_id_valid_o), 32'h1);
    check("lit_c2_pc",    if_id_pc_o,  32'h0);
    check("lit_c2_addr",  imem_addr_o, 32'h8);

    // Stall for 3 cycles while the response for 0x8 arrives.
    step(1'b1, 1'b0, 32'h0);
    check("lit_stall_pc",  if_id_pc_o, 32'h4);
    check("lit_stall_req", 32'(imem_req_o), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("lit_stall3_pc",  if_id_pc_o, 32'h4);
    check("lit_stall3_req", 32'(imem_req_o), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("lit_unstall_pc", if_id_pc_o, 32'h4);
    mem_lat = 3;
    step(1'b0, 1'b0, 32'h0);
    check("lit_skid_pc",    if_id_pc_o,    32'h8);
    check("lit_skid_instr", if_id_instr_o, mem_word(32'h8));
    check("lit_after_addr", imem_addr_o,   32'hC);

    // Redirect to 0x103 while waiting; the response arrives two cycles later.
    step(1'b0, 1'b1, 32'h0000_0103);
    check("lit_redir_req", 32'(imem_req_o), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("lit_drain_req", 32'(imem_req_o), 32'h0);
    mem_lat = 1;
    step(1'b0, 1'b0, 32'h0);
    check("lit_tgt_addr",  imem_addr_o,        32'h100);
    check("lit_tgt_valid", 32'(if_id_valid_o), 32'h0);
    check("lit_tgt_instr", if_id_instr_o,      NOP);

    // Redirect coincident with rvalid and stall, target near the top of memory.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    check("lit_rs_req", 32'(imem_req_o), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("lit_rs_addr",  imem_addr_o,        32'hFFFF_FFFC);
    check("lit_rs_valid", 32'(if_id_valid_o), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("lit_wrap_addr", imem_addr_o, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("lit_wrap_pc",  if_id_pc_o,  32'hFFFF_FFFC);
    check("lit_wrap_pc4", if_id_pc4_o, 32'h0);

    // Asynchronous reset pulse during WAIT, then a stray response after release.
    @(posedge clk_i); #1; stall_i = 1'b0; redirect_i = 1'b0;
    #2; reset_i = 1'b0; stray = 1'b1;
    #1;
    check("lit_async_req",   32'(imem_req_o),    32'h0);
    check("lit_async_valid", 32'(if_id_valid_o), 32'h0);
    check("lit_async_instr", if_id_instr_o,      NOP);
    check("lit_async_pc",    if_id_pc_o,         32'h0);
    @(posedge clk_i); #1; reset_i = 1'b1; @(negedge clk_i);
    check("lit_rel_req",  32'(imem_req_o), 32'h1);
    check("lit_rel_addr", imem_addr_o,     RESET_PC);
    step(1'b0, 1'b0, 32'h0);
    check("lit_stray_valid", 32'(if_id_valid_o), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("lit_rel_pc",    if_id_pc_o,    RESET_PC);
    check("lit_rel_instr", if_id_instr_o, mem_word(RESET_PC));

    // Random traffic with variable memory latency.
    mem_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(posedge clk_i); #1; reset_i = 1'b0;
        @(posedge clk_i); #1; reset_i = 1'b1;
      end
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step(s, r, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
